timer_arbiter: RTL and testbench

Shares one prescaled countdown timer among N_REQ requesters in the vending controller: dispense hold, coin-return delay, display blink, idle timeout. A round-robin arbiter grants the timer to one requester at a time and loads that requester's duration. The block counts the duration in prescaler ticks derived from the 50 MHz board clock, then pulses `done` back to the owner. The divider is built in, so no separate slow-clock domain is needed.

---
 rtl/timer_sched_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/timer_arbiter.sv | 154 +++++++++++++++
 tb/tb_timer_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the prescaled timer scheduler.
// State encoding, default divider/duration sizing and a constant-foldable clog2.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StCount = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefaultDiv  = 50000;
    localparam int unsigned DefaultDurW = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// clr_i restarts the count from zero; tick_o is only asserted while en_i is high.
module tick_prescaler
    import timer_sched_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic clk_50MHz_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = clog2(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_50MHz_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin shared countdown timer: grants one requester, counts its duration in
// prescaler ticks, then pulses done. TIMER_ABORT_EN lets the owner cancel by dropping req.
module timer_arbiter
    import timer_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DIV   = DefaultDiv,
    parameter int unsigned DUR_W = DefaultDurW
) (
    input  logic                   clk_50MHz_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*DUR_W-1:0] dur_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   busy_o,
    output logic                   tick_o,
    output logic [DUR_W-1:0]       remain_o
);

    localparam int unsigned SelW = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] OneBit = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef logic [SelW-1:0] sel_t;

    state_e           state_q, state_d;
    sel_t             sel_q, sel_d, ptr_q, ptr_d;
    sel_t             arb_sel, sel_next;
    logic             arb_valid;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic [N_REQ-1:0] sel_onehot, arb_onehot;
    logic [DUR_W-1:0] remain_q, remain_d, sel_dur;
    logic             tick;
    logic             abort;

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk_50MHz_i(clk_50MHz_i),
        .rst_i      (rst_i),
        .clr_i      (state_q != StCount),
        .en_i       (state_q == StCount),
        .tick_o     (tick)
    );

    // First pending request at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        arb_valid = 1'b0;
        arb_sel   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr_q) + i) % N_REQ;
            if (!arb_valid && req_i[idx]) begin
                arb_valid = 1'b1;
                arb_sel   = sel_t'(idx);
            end
        end
    end

    assign sel_next   = (sel_q == sel_t'(N_REQ - 1)) ? '0 : sel_q + sel_t'(1);
    assign sel_onehot = OneBit << sel_q;
    assign arb_onehot = OneBit << arb_sel;
    assign sel_dur    = dur_i[32'(sel_q) * DUR_W +: DUR_W];

`ifdef TIMER_ABORT_EN
    assign abort = !req_i[sel_q];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        remain_d = remain_q;
        unique case (state_q)
            StIdle: begin
                gnt_d    = '0;
                remain_d = '0;
                if (arb_valid) begin
                    sel_d   = arb_sel;
                    gnt_d   = arb_onehot;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    remain_d = '0;
                    ptr_d    = sel_next;
                end else begin
                    remain_d = sel_dur;
                    if (sel_dur == '0) begin
                        state_d = StDone;
                        done_d  = sel_onehot;
                    end else begin
                        state_d = StCount;
                    end
                end
            end
            StCount: begin
                if (abort) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    remain_d = '0;
                    ptr_d    = sel_next;
                end else if (tick) begin
                    if (remain_q == DUR_W'(1)) begin
                        state_d  = StDone;
                        remain_d = '0;
                        done_d   = sel_onehot;
                    end else begin
                        remain_d = remain_q - DUR_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                ptr_d   = sel_next;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50MHz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            remain_q <= remain_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != StIdle);
    assign tick_o   = tick;
    assign remain_o = remain_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus random traffic against a job-timeline
// model (grant edge + duration -> expected outputs). Honours TIMER_ABORT_EN.
module tb_timer_arbiter;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   dur = '0;
    logic [N-1:0]      gnt, done;
    logic              busy, tick;
    logic [DW-1:0]     remain;

    always #5 clk = ~clk;

    timer_arbiter #(
        .N_REQ(N),
        .DIV  (DIV),
        .DUR_W(DW)
    ) dut (
        .clk_50MHz_i(clk),
        .rst_i      (rst),
        .req_i      (req),
        .dur_i      (dur),
        .gnt_o      (gnt),
        .done_o     (done),
        .busy_o     (busy),
        .tick_o     (tick),
        .remain_o   (remain)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    // Model: a job is (owner, grant edge t0, latched duration); outputs follow from age.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_t0     = 0;
    int m_dur    = 0;
    int m_ptr    = 0;

    logic [N-1:0]  e_gnt, e_done;
    logic          e_busy, e_tick;
    logic [DW-1:0] e_remain;

    int           last_done_n;
    logic [N-1:0] last_done_vec;
    int           done3_n;
    int           tick_cnt;
    int           grant_q[$];
    logic [N-1:0] prev_gnt = '0;
    bit           drop_on_done = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int dur_of(input int idx);
        return int'(dur[idx*DW +: DW]);
    endfunction

    // 0 = LOAD, 1 = COUNT, 2 = DONE, 3 = finished; a = cycles since the grant edge.
    function automatic int phase_of(input int a);
        if (a == 0) return 0;
        if (m_dur == 0) return (a == 1) ? 2 : 3;
        if (a <= DIV * m_dur) return 1;
        if (a == DIV * m_dur + 1) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_ptr    = 0;
    endtask

    task automatic model_edge();
        int ph;
        n++;
        if (m_active) begin
            ph = phase_of(n - 1 - m_t0);
            if (ph == 0) m_dur = dur_of(m_owner);
            if (ph >= 2) begin
                m_active = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
`ifdef TIMER_ABORT_EN
            else if (!req[m_owner]) begin
                m_active = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
`endif
        end else if (req != '0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
            end
            m_active = 1'b1;
            m_t0     = n;
        end
    endtask

    task automatic model_expect();
        int a, c, ph;
        e_gnt = '0; e_done = '0; e_busy = 1'b0; e_tick = 1'b0; e_remain = '0;
        if (m_active) begin
            a  = n - m_t0;
            ph = phase_of(a);
            e_busy = 1'b1;
            e_gnt  = N'(1) << m_owner;
            if (ph == 1) begin
                c        = a - 1;
                e_remain = DW'(m_dur - c / DIV);
                e_tick   = ((c % DIV) == DIV - 1);
            end else if (ph == 2) begin
                e_done = N'(1) << m_owner;
            end
        end
    endtask

    task automatic check_all();
        check_eq("gnt", 32'(gnt), 32'(e_gnt));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("tick", 32'(tick), 32'(e_tick));
        check_eq("remain", 32'(remain), 32'(e_remain));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_expect();
        check_all();
        if (done != '0) begin
            last_done_n   = n;
            last_done_vec = done;
        end
        if (done[3]) done3_n = n;
        if (tick) tick_cnt++;
        if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) grant_q.push_back(i);
        end
        prev_gnt = gnt;
        if (drop_on_done) req = req & ~e_done;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        model_expect();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst      = 1'b0;
        prev_gnt = '0;
    endtask

    task automatic clear_marks();
        last_done_n   = -1;
        last_done_vec = '0;
        done3_n       = -1;
        tick_cnt      = 0;
        grant_q.delete();
    endtask

    initial begin
        int e0;
        bit dropped;

        // Single job, dur=3: done 13 edges after the grant, 3 ticks.
        do_reset();
        clear_marks();
        dur[1*DW +: DW] = 16'd3;
        req = 4'b0010;
        step();
        e0 = n;
        check_eq("s1_gnt", 32'(gnt), 32'h2);
        repeat (14) step();
        check_eq("s1_done_at", 32'(last_done_n - e0), 32'd13);
        check_eq("s1_ticks", 32'(tick_cnt), 32'd3);
        check_eq("s1_busy_end", 32'(busy), 32'd0);

        // Round-robin order from pointer 0.
        do_reset();
        clear_marks();
        for (int i = 0; i < N; i++) dur[i*DW +: DW] = 16'd1;
        req = 4'b1011;
        repeat (30) step();
        check_eq("s2_grants", 32'(grant_q.size()), 32'd3);
        if (grant_q.size() == 3) begin
            check_eq("s2_first", 32'(grant_q[0]), 32'd0);
            check_eq("s2_second", 32'(grant_q[1]), 32'd1);
            check_eq("s2_third", 32'(grant_q[2]), 32'd3);
        end

        // Zero duration: done right after LOAD, never a tick.
        clear_marks();
        dur[2*DW +: DW] = 16'd0;
        req = 4'b0100;
        step();
        e0 = n;
        repeat (4) step();
        check_eq("s3_done_at", 32'(last_done_n - e0), 32'd1);
        check_eq("s3_done_vec", 32'(last_done_vec), 32'h4);
        check_eq("s3_ticks", 32'(tick_cnt), 32'd0);

        // Reset mid-count: no done, then full re-count for the still-held request.
        do_reset();
        clear_marks();
        dur[0*DW +: DW] = 16'd5;
        req = 4'b0001;
        repeat (9) step();
        do_reset();
        check_eq("s4_no_done", 32'(last_done_n), 32'hffff_ffff);
        step();
        e0 = n;
        check_eq("s4_regrant", 32'(gnt), 32'h1);
        repeat (22) step();
        check_eq("s4_done_at", 32'(last_done_n - e0), 32'd21);
        check_eq("s4_done_vec", 32'(last_done_vec), 32'h1);

        // Pointer is now 1: requester 3 wins, then drops req after two ticks.
        clear_marks();
        dur[3*DW +: DW] = 16'd6;
        dur[0*DW +: DW] = 16'd1;
        req = 4'b1001;
        step();
        e0 = n;
        check_eq("s5_gnt", 32'(gnt), 32'h8);
        dropped = 1'b0;
        repeat (40) begin
            step();
            if (!dropped && tick_cnt == 2) begin
                req[3]  = 1'b0;
                dropped = 1'b1;
            end
        end
`ifdef TIMER_ABORT_EN
        check_eq("s5_no_done3", 32'(done3_n), 32'hffff_ffff);
`else
        check_eq("s5_done3_at", 32'(done3_n - e0), 32'd25);
`endif
        check_eq("s5_grants", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() >= 2) check_eq("s5_next_owner", 32'(grant_q[1]), 32'd0);

        // Random traffic against the model.
        do_reset();
        drop_on_done = 1'b1;
        repeat (2500) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) dur[i*DW +: DW] = DW'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
